free_list: RTL and testbench

//  Circular FIFO of unallocated physical register indices feeding rename_dispatch.
//  - Rename pops one index per instruction that writes rd.
//  - ROB commit pushes back the stale mapping of each retiring instruction.
//  - A retirement copy of the head pointer allows one-cycle recovery on pipeline flush.

---
 rtl/free_list_pkg.sv | 13 +
 rtl/free_list_if.sv | 31 +++
 rtl/free_list.sv | 85 ++++++++
 tb/tb_free_list.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/free_list_pkg.sv
// Shared constants and types for the physical-register free list.
package free_list_pkg;

   localparam int FL_PHYS_REG_BITS = 6;
   localparam int FL_ARCH_REGS     = 32;

   typedef logic [FL_PHYS_REG_BITS-1:0] phys_reg_t;

   function automatic int fl_depth(input int phys_reg_bits, input int arch_regs);
      return (1 << phys_reg_bits) - arch_regs;
   endfunction

endpackage

// File: rtl/free_list_if.sv
// Rename/commit-side handshake bundle of the free list.
interface free_list_if
   import free_list_pkg::*;
#(
   parameter int PHYS_REG_BITS = FL_PHYS_REG_BITS,
   parameter int ARCH_REGS     = FL_ARCH_REGS
);

   localparam int DEPTH = fl_depth(PHYS_REG_BITS, ARCH_REGS);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                     dequeue;
   logic [PHYS_REG_BITS-1:0] phys_reg;
   logic                     is_free_list_empty;
   logic                     enqueue;
   logic [PHYS_REG_BITS-1:0] enqueue_reg;
   logic                     flush;
   logic [CNT_W-1:0]         free_count;
   logic                     overflow_err;

   modport master (
      output dequeue, enqueue, enqueue_reg, flush,
      input  phys_reg, is_free_list_empty, free_count, overflow_err
   );

   modport slave (
      input  dequeue, enqueue, enqueue_reg, flush,
      output phys_reg, is_free_list_empty, free_count, overflow_err
   );

endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical register indices with a retirement head
// copy so a flush restores every speculative allocation in one cycle.
module free_list
   import free_list_pkg::*;
#(
   parameter int PHYS_REG_BITS = FL_PHYS_REG_BITS,
   parameter int ARCH_REGS     = FL_ARCH_REGS
) (
   input  logic        clk,
   input  logic        rst,
   free_list_if.slave  fl
);

   localparam int DEPTH = fl_depth(PHYS_REG_BITS, ARCH_REGS);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0]         head_q, head_d;
   logic [PTR_W-1:0]         tail_q, tail_d;
   logic [PTR_W-1:0]         retire_head_q, retire_head_d;
   logic [PHYS_REG_BITS-1:0] mem_q [DEPTH];
   logic [PHYS_REG_BITS-1:0] mem_d [DEPTH];
   logic                     overflow_err_q, overflow_err_d;

   logic empty;
   logic full;
   logic enq_ok;
   logic deq_ok;

   always_comb begin
      empty  = (head_q == tail_q);
      full   = (head_q[PTR_W-1] != tail_q[PTR_W-1]) &&
               (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]);
      // x0 never maps to a physical register, so returning it is a no-op.
      enq_ok = fl.enqueue && (fl.enqueue_reg != '0) && !full;
      deq_ok = fl.dequeue && !empty && !fl.flush;

      mem_d          = mem_q;
      tail_d         = tail_q;
      retire_head_d  = retire_head_q;
      overflow_err_d = overflow_err_q;

      if (enq_ok) begin
         mem_d[tail_q[IDX_W-1:0]] = fl.enqueue_reg;
         tail_d                   = tail_q + PTR_W'(1);
         retire_head_d            = retire_head_q + PTR_W'(1);
      end
      if (fl.enqueue && (fl.enqueue_reg != '0) && full) begin
         overflow_err_d = 1'b1;
      end

      // Flush uses the post-enqueue retire head so a same-cycle commit counts.
      if (fl.flush) begin
         head_d = retire_head_d;
      end else if (deq_ok) begin
         head_d = head_q + PTR_W'(1);
      end else begin
         head_d = head_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= PHYS_REG_BITS'(ARCH_REGS + i);
         end
         head_q         <= '0;
         retire_head_q  <= '0;
         tail_q         <= PTR_W'(DEPTH);
         overflow_err_q <= 1'b0;
      end else begin
         mem_q          <= mem_d;
         head_q         <= head_d;
         retire_head_q  <= retire_head_d;
         tail_q         <= tail_d;
         overflow_err_q <= overflow_err_d;
      end
   end

   assign fl.phys_reg           = mem_q[head_q[IDX_W-1:0]];
   assign fl.is_free_list_empty = empty;
   assign fl.free_count         = tail_q - head_q;
   assign fl.overflow_err       = overflow_err_q;

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios plus a random run against an
// unbounded-counter model of the free list.
module tb_free_list;
   import free_list_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   // Model: absolute (never wrapping) counters into a write log.
   int        m_head, m_tail, m_ret;
   bit        m_ovf;
   phys_reg_t m_log [int];

   free_list_if fl_if ();

   free_list dut (
      .clk (clk),
      .rst (rst),
      .fl  (fl_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_log.delete();
      for (int i = 0; i < 32; i++) m_log[i] = phys_reg_t'(32 + i);
      m_head = 0;
      m_tail = 32;
      m_ret  = 0;
      m_ovf  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      fl_if.dequeue     = 1'b0;
      fl_if.enqueue     = 1'b0;
      fl_if.enqueue_reg = '0;
      fl_if.flush       = 1'b0;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Apply one cycle of stimulus, advance the model from the pre-edge state.
   task automatic step(input bit deq, input bit enq, input int r, input bit fl);
      bit full, empty, enq_ok, deq_ok;
      fl_if.dequeue     = deq;
      fl_if.enqueue     = enq;
      fl_if.enqueue_reg = phys_reg_t'(r);
      fl_if.flush       = fl;
      full   = (m_tail - m_head) == 32;
      empty  = (m_tail == m_head);
      enq_ok = enq && (r != 0) && !full;
      deq_ok = deq && !empty && !fl;
      if (enq && (r != 0) && full) m_ovf = 1'b1;
      if (enq_ok) begin
         m_log[m_tail] = phys_reg_t'(r);
         m_tail++;
         m_ret++;
      end
      if (fl) m_head = m_ret;
      else if (deq_ok) m_head++;
      @(posedge clk);
      #1;
      fl_if.dequeue     = 1'b0;
      fl_if.enqueue     = 1'b0;
      fl_if.enqueue_reg = '0;
      fl_if.flush       = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (fl_if.phys_reg !== 6'd32) begin
         failures++;
         $display("FAIL reset_phys_reg got=%0d exp=32", fl_if.phys_reg);
      end
      checks++;
      if (fl_if.free_count !== 6'd32) begin
         failures++;
         $display("FAIL reset_free_count got=%0d exp=32", fl_if.free_count);
      end
      checks++;
      if (fl_if.is_free_list_empty !== 1'b0) begin
         failures++;
         $display("FAIL reset_empty got=%b exp=0", fl_if.is_free_list_empty);
      end
      checks++;
      if (fl_if.overflow_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_overflow got=%b exp=0", fl_if.overflow_err);
      end
   endtask

   task automatic test_drain_recycle();
      do_reset();
      @(posedge clk);
      #1;
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (fl_if.phys_reg !== phys_reg_t'(32 + i)) begin
            failures++;
            $display("FAIL drain_seq[%0d] got=%0d exp=%0d", i, fl_if.phys_reg, 32 + i);
         end
         step(1, 0, 0, 0);
      end
      checks++;
      if (fl_if.is_free_list_empty !== 1'b1 || fl_if.free_count !== 6'd0) begin
         failures++;
         $display("FAIL drain_empty got=%b/%0d exp=1/0", fl_if.is_free_list_empty, fl_if.free_count);
      end
      step(1, 0, 0, 0);
      checks++;
      if (fl_if.is_free_list_empty !== 1'b1 || fl_if.free_count !== 6'd0) begin
         failures++;
         $display("FAIL drain_extra_deq got=%b/%0d exp=1/0", fl_if.is_free_list_empty, fl_if.free_count);
      end
      step(0, 1, 40, 0);
      step(0, 1, 7, 0);
      checks++;
      if (fl_if.free_count !== 6'd2 || fl_if.phys_reg !== 6'd40) begin
         failures++;
         $display("FAIL recycle_state got=%0d/%0d exp=2/40", fl_if.free_count, fl_if.phys_reg);
      end
      step(1, 0, 0, 0);
      checks++;
      if (fl_if.phys_reg !== 6'd7) begin
         failures++;
         $display("FAIL recycle_second got=%0d exp=7", fl_if.phys_reg);
      end
      step(1, 0, 0, 0);
      checks++;
      if (fl_if.is_free_list_empty !== 1'b1 || fl_if.free_count !== 6'd0) begin
         failures++;
         $display("FAIL recycle_drained got=%b/%0d exp=1/0", fl_if.is_free_list_empty, fl_if.free_count);
      end
   endtask

   task automatic test_flush_recovery();
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
      for (int i = 1; i <= 3; i++) step(0, 1, i, 0);
      step(0, 0, 0, 1);
      checks++;
      if (fl_if.phys_reg !== 6'd35) begin
         failures++;
         $display("FAIL flush_phys_reg got=%0d exp=35", fl_if.phys_reg);
      end
      checks++;
      if (fl_if.free_count !== 6'd32) begin
         failures++;
         $display("FAIL flush_free_count got=%0d exp=32", fl_if.free_count);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      for (int i = 0; i < 22; i++) step(1, 0, 0, 0);
      step(1, 1, 9, 0);
      checks++;
      if (fl_if.free_count !== 6'd10) begin
         failures++;
         $display("FAIL enq_deq_count got=%0d exp=10", fl_if.free_count);
      end
      checks++;
      if (fl_if.phys_reg !== 6'd55) begin
         failures++;
         $display("FAIL enq_deq_phys got=%0d exp=55", fl_if.phys_reg);
      end
      // retire head sits at 1 after the single commit, so flush lands on reg 33.
      step(1, 0, 0, 1);
      checks++;
      if (fl_if.phys_reg !== 6'd33 || fl_if.free_count !== 6'd32) begin
         failures++;
         $display("FAIL flush_deq got=%0d/%0d exp=33/32", fl_if.phys_reg, fl_if.free_count);
      end
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      checks++;
      if (fl_if.free_count !== 6'd31 || fl_if.phys_reg !== 6'd34 || fl_if.overflow_err !== 1'b0) begin
         failures++;
         $display("FAIL enq_x0 got=%0d/%0d/%b exp=31/34/0", fl_if.free_count, fl_if.phys_reg, fl_if.overflow_err);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      step(0, 1, 5, 0);
      checks++;
      if (fl_if.overflow_err !== 1'b1 || fl_if.free_count !== 6'd32) begin
         failures++;
         $display("FAIL ovf_set got=%b/%0d exp=1/32", fl_if.overflow_err, fl_if.free_count);
      end
      step(1, 0, 0, 0);
      step(0, 1, 12, 0);
      step(0, 0, 0, 0);
      checks++;
      if (fl_if.overflow_err !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky got=%b exp=1", fl_if.overflow_err);
      end
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (fl_if.overflow_err !== 1'b0 || fl_if.free_count !== 6'd32 || fl_if.phys_reg !== 6'd32) begin
         failures++;
         $display("FAIL ovf_async_clear got=%b/%0d/%0d exp=0/32/32", fl_if.overflow_err, fl_if.free_count, fl_if.phys_reg);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_random();
      bit deq, enq, fl;
      int r;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         deq = ($urandom_range(0, 99) < 50);
         enq = ($urandom_range(0, 99) < 45);
         fl  = ($urandom_range(0, 99) < 5);
         r   = $urandom_range(0, 63);
         if ($urandom_range(0, 9) == 0) r = 0;
         step(deq, enq, r, fl);
         checks++;
         if (fl_if.free_count !== 6'(m_tail - m_head)) begin
            failures++;
            $display("FAIL rand_count[%0d] got=%0d exp=%0d", n, fl_if.free_count, m_tail - m_head);
         end
         checks++;
         if (fl_if.is_free_list_empty !== (m_tail == m_head)) begin
            failures++;
            $display("FAIL rand_empty[%0d] got=%b exp=%b", n, fl_if.is_free_list_empty, m_tail == m_head);
         end
         checks++;
         if (fl_if.overflow_err !== m_ovf) begin
            failures++;
            $display("FAIL rand_ovf[%0d] got=%b exp=%b", n, fl_if.overflow_err, m_ovf);
         end
         if (m_tail != m_head) begin
            checks++;
            if (fl_if.phys_reg !== m_log[m_head]) begin
               failures++;
               $display("FAIL rand_phys[%0d] got=%0d exp=%0d", n, fl_if.phys_reg, m_log[m_head]);
            end
         end
      end
   endtask

   initial begin
      checks            = 0;
      failures          = 0;
      rst               = 1'b0;
      fl_if.dequeue     = 1'b0;
      fl_if.enqueue     = 1'b0;
      fl_if.enqueue_reg = '0;
      fl_if.flush       = 1'b0;
      test_reset();
      test_drain_recycle();
      test_flush_recovery();
      test_same_cycle();
      test_overflow();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
